// File: rtl/keycode_event_queue.sv
// Turns a 4-slot HID keycode word into ordered release/press events
// by diffing it against the last accepted snapshot. Events are queued in a show-ahead FIFO.
module keycode_event_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [31:0]      keycode_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [7:0]       evt_code_o,
    output logic             evt_press_o,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic [31:0]      held_o,
    output logic             busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN_REL, SCAN_PRS, COMMIT} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [31:0]                 kc_q, snap_q, snap_d, new_q, new_d, old_q, old_d;
    logic [FIFO_DEPTH-1:0][8:0]  mem_q;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;

    logic        kc_valid, qual, hit, full, push, pop;
    logic [31:0] cur, oth;
    logic [7:0]  slot;

    always_comb begin
        kc_valid = 1'b1;
        for (int k = 0; k < 4; k++)
            if (kc_q[k*8 +: 8] == 8'h01) kc_valid = 1'b0;
    end

    // Release phase walks the old word looking for slots missing from the new one;
    // the press phase is the mirror image. Lower equal slots suppress duplicates.
    always_comb begin
        cur  = (state_q == SCAN_REL) ? old_q : new_q;
        oth  = (state_q == SCAN_REL) ? new_q : old_q;
        slot = cur[{idx_q, 3'b000} +: 8];
        hit  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (oth[k*8 +: 8] == slot) hit = 1'b1;
            if (k < int'(idx_q) && cur[k*8 +: 8] == slot) hit = 1'b1;
        end
        qual = (state_q == SCAN_REL || state_q == SCAN_PRS) && slot != 8'h00 && !hit;
    end

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push = qual && !full;
    assign pop  = (count_q != '0) && evt_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        new_d   = new_q;
        old_d   = old_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (kc_valid && kc_q != snap_q) begin
                    new_d   = kc_q;
                    old_d   = snap_q;
                    idx_d   = 2'd0;
                    state_d = SCAN_REL;
                end
            end
            SCAN_REL, SCAN_PRS: begin
                // A qualifying slot with no FIFO room holds the scan in place.
                if (!(qual && full)) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3)
                        state_d = (state_q == SCAN_REL) ? SCAN_PRS : COMMIT;
                end
            end
            COMMIT: begin
                snap_d  = new_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            kc_q    <= '0;
            snap_q  <= '0;
            new_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            kc_q    <= keycode_i;
            snap_q  <= snap_d;
            new_q   <= new_d;
            old_q   <= old_d;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {state_q == SCAN_PRS, slot};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign evt_valid_o               = (count_q != '0);
    assign {evt_press_o, evt_code_o} = mem_q[rd_ptr_q];
    assign fifo_count_o              = count_q;
    assign held_o                    = snap_q;
    assign busy_o                    = (state_q != IDLE);
endmodule

// File: tb/tb_keycode_event_queue.sv
// Randomized bench for keycode_event_queue: an event-list/queue model is compared every cycle,
// plus directed scenarios with literal event sequences.
module tb_keycode_event_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   kc = '0;
    logic          ready = 1'b0;
    logic          evt_valid, evt_press, busy;
    logic [7:0]    evt_code;
    logic [CW-1:0] count;
    logic [31:0]   held;

    int checks = 0;
    int passes = 0;

    keycode_event_queue #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .keycode_i(kc),
        .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_code_o(evt_code),
        .evt_press_o(evt_press), .fifo_count_o(count), .held_o(held), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic v; logic [8:0] e; } step_t;
    logic [31:0] m_kc, m_snap, m_new;
    bit          m_scan;
    int          m_step;
    step_t       m_list [8];
    logic [8:0]  m_q [$];
    logic [8:0]  log_q [$];

    function automatic logic [7:0] sl(input logic [31:0] w, input int s);
        return w[s*8 +: 8];
    endfunction

    function automatic bit in_first(input logic [31:0] w, input logic [7:0] c, input int n);
        for (int s = 0; s < n; s++) if (sl(w, s) == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit word_ok(input logic [31:0] w);
        return !in_first(w, 8'h01, 4);
    endfunction

    // Eight scan steps: four release candidates from old, then four press candidates from new.
    task automatic build(input logic [31:0] o, input logic [31:0] n);
        for (int s = 0; s < 4; s++) begin
            m_list[s].e   = {1'b0, sl(o, s)};
            m_list[s].v   = sl(o, s) != 0 && !in_first(n, sl(o, s), 4) && !in_first(o, sl(o, s), s);
            m_list[s+4].e = {1'b1, sl(n, s)};
            m_list[s+4].v = sl(n, s) != 0 && !in_first(o, sl(n, s), 4) && !in_first(n, sl(n, s), s);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_kc = '0; m_snap = '0; m_new = '0; m_scan = 0; m_step = 0;
            m_q.delete();
        end else begin
            bit pop, full, push;
            logic [8:0] pv;
            pop  = m_q.size() != 0 && ready;
            full = m_q.size() == DEPTH;
            push = 0;
            pv   = '0;
            if (m_scan) begin
                if (m_step == 8) begin
                    m_snap = m_new;
                    m_scan = 0;
                end else if (!(m_list[m_step].v && full)) begin
                    if (m_list[m_step].v) begin push = 1; pv = m_list[m_step].e; end
                    m_step++;
                end
            end else if (word_ok(m_kc) && m_kc != m_snap) begin
                build(m_snap, m_kc);
                m_new  = m_kc;
                m_scan = 1;
                m_step = 0;
            end
            m_kc = kc;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(pv);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("valid", evt_valid, m_q.size() != 0);
        chk("count", count, m_q.size());
        chk("held", held, m_snap);
        chk("busy", busy, m_scan);
        if (m_q.size() != 0) chk("head", {evt_press, evt_code}, m_q[0]);
        if (evt_valid && ready) log_q.push_back({evt_press, evt_code});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic settle();
        int idle = 0, n = 0;
        ready = 1'b1;
        cyc(3);
        while (idle < 3 && n < 300) begin
            if (!busy && !evt_valid) idle++; else idle = 0;
            cyc(1);
            n++;
        end
        if (idle < 3) begin
            checks++;
            $display("FAIL settle: timed out busy=%0b valid=%0b", busy, evt_valid);
        end
    endtask

    task automatic chk_log(input string name, input logic [8:0] exp [$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int k = 0; k < exp.size() && k < log_q.size(); k++)
            chk(name, log_q[k], exp[k]);
    endtask

    function automatic logic [8:0] P(input logic [7:0] c); return {1'b1, c}; endfunction
    function automatic logic [8:0] R(input logic [7:0] c); return {1'b0, c}; endfunction

    initial begin
        logic [8:0] e [$];
        bit busy_seen;
        cyc(3);
        chk("rst_valid", evt_valid, 0); chk("rst_code", evt_code, 0);
        chk("rst_press", evt_press, 0); chk("rst_count", count, 0);
        chk("rst_held", held, 0);       chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc(2);

        // single press: visible after edge 7, release after edge 3
        kc = 32'h4;
        cyc(6); chk("p_lat_early", evt_valid, 0);
        cyc(1); chk("p_lat", evt_valid, 1); chk("p_code", evt_code, 8'h04); chk("p_press", evt_press, 1);
        cyc(5); chk("p_held", held, 32'h4);
        ready = 1'b1; cyc(1); ready = 1'b0;
        kc = 32'h0;
        cyc(2); chk("r_lat_early", evt_valid, 0);
        cyc(1); chk("r_lat", evt_valid, 1); chk("r_code", evt_code, 8'h04); chk("r_press", evt_press, 0);
        settle();

        // shared key stays silent
        kc = 32'h504; settle();
        log_q.delete(); kc = 32'h604; settle();
        e = '{R(8'h05), P(8'h06)}; chk_log("swap", e); chk("swap_held", held, 32'h604);

        // duplicates, then an ErrorRollOver word
        kc = 32'h0; settle();
        log_q.delete(); kc = 32'h404; settle();
        e = '{P(8'h04)}; chk_log("dup", e);
        kc = 32'h01010101; busy_seen = 0;
        repeat (20) begin cyc(1); if (busy) busy_seen = 1; end
        chk("err_busy", busy_seen, 0); chk("err_held", held, 32'h404); chk("err_count", count, 0);

        // stall on a full FIFO
        kc = 32'h0; settle();
        ready = 1'b0; log_q.delete();
        kc = 32'h04050607; cyc(20);
        chk("st_cnt4", count, 4); chk("st_idle", busy, 0);
        kc = 32'h08090A0B; cyc(20);
        chk("st_cnt8", count, 8); chk("st_busy", busy, 1);
        settle();
        e = '{P(8'h07), P(8'h06), P(8'h05), P(8'h04), R(8'h07), R(8'h06), R(8'h05), R(8'h04),
              P(8'h0B), P(8'h0A), P(8'h09), P(8'h08)};
        chk_log("stall", e); chk("st_held", held, 32'h08090A0B);

        // input changes one cycle into the scan
        kc = 32'h0; settle();
        log_q.delete();
        kc = 32'h4; cyc(1); kc = 32'h5; settle();
        e = '{P(8'h04), R(8'h04), P(8'h05)}; chk_log("mid", e); chk("mid_held", held, 32'h5);

        // reset during the press phase with three events queued
        kc = 32'h0; settle();
        ready = 1'b0;
        kc = 32'h00070605; cyc(9);
        chk("mr_cnt", count, 3); chk("mr_busy", busy, 1);
        rst_n = 1'b0; kc = 32'h0; #1;
        chk("mr_valid", evt_valid, 0); chk("mr_count", count, 0); chk("mr_busy0", busy, 0);
        chk("mr_held", held, 0); chk("mr_code", evt_code, 0); chk("mr_press", evt_press, 0);
        cyc(2); rst_n = 1'b1; cyc(2);
        log_q.delete(); kc = 32'h7; settle();
        e = '{P(8'h07)}; chk_log("post_rst", e);

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [31:0] w;
                for (int s = 0; s < 4; s++) begin
                    int r;
                    r = $urandom_range(0, 7);
                    w[s*8 +: 8] = (r < 2) ? 8'h00 : 8'(r + 2);
                end
                if ($urandom_range(0, 19) == 0) w[$urandom_range(0, 3)*8 +: 8] = 8'h01;
                kc = w;
            end
            ready = ((t / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        settle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
